voice_scheduler: RTL and testbench
==================================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter: NUM_VOICES, default 3, number of voices sequenced per sample frame (fixed at 3 in this release).
REQ-002 Parameter: WDT_CYCLES, default 8, maximum cycles from start_o to ready_i before a voice is aborted.
REQ-003 clk_i  in  1  system clock (50 MHz).
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 sample_tick_i  in  1  one-cycle pulse at sample rate (50 kHz) that starts a frame.
REQ-006 freq_word_i  in  3x16  per-voice frequency words.
REQ-007 pw_word_i  in  3x12  per-voice pulse widths.
REQ-008 wave_sel_i  in  3x4  per-voice waveform selects.
REQ-009 sync_i, ring_mod_i  in  3x1 each  per-voice sync and ring-mod enables.
REQ-010 status_clr_i  in  1  clears sticky status flags.
REQ-011 start_o, act_voice_o[1:0], freq_word_o[15:0], pw_word_o[11:0], wave_sel_o[3:0], sync_o, ring_mod_o  out  voice-generator command bus.
REQ-012 ready_i  in  1  voice-generator completion pulse.
REQ-013 wave_i  in  10 signed  voice-generator output.
REQ-014 voice_wave_o  out  3x10 signed  latest captured sample per voice.
REQ-015 sample_valid_o  out  1  one-cycle pulse when all voices are updated.
REQ-016 busy_o, overrun_o, timeout_o  out  1 each  frame active, sticky tick-overrun flag, sticky watchdog flag.

Function
REQ-017 The FSM shall have states IDLE, START, WAIT and DONE.
REQ-018 IDLE: on sample_tick_i=1, set act_voice_o=0 and go to START.
REQ-019 START: drive start_o=1 for exactly one cycle, clear the watchdog counter, and go to WAIT.
REQ-020 WAIT: on ready_i=1, capture wave_i into voice_wave_o[act_voice_o]. Then, if act_voice_o=NUM_VOICES-1, go to DONE; otherwise increment act_voice_o and go to START.
REQ-021 DONE: drive sample_valid_o=1 for one cycle and go to IDLE.
REQ-022 Config outputs shall be a combinational mux of the per-voice inputs indexed by registered act_voice_o, so they stay stable from START until ready_i.
REQ-023 With a generator that raises ready_i 3 cycles after start_o, sample_valid_o shall rise 13 cycles after the sample_tick_i cycle.
REQ-024 Watchdog: if ready_i has not arrived WDT_CYCLES cycles after start_o, the voice's sample shall hold its old value, timeout_o shall set, and the FSM shall advance exactly as on ready_i.
REQ-025 ready_i in IDLE, START or DONE shall be ignored.
REQ-026 sample_tick_i in any state other than IDLE shall set overrun_o and be dropped; the current frame continues unaffected.
REQ-027 On status_clr_i=1 with a simultaneous set event, the set shall win.
REQ-028 busy_o shall be 1 in every state except IDLE.

Reset
REQ-029 While rst_ni=0: state=IDLE, act_voice_o=0, start_o=0, sample_valid_o=0, all voice_wave_o=0, overrun_o=0, timeout_o=0, watchdog counter=0.
REQ-030 Reset asserted mid-frame shall abort the frame immediately with no sample_valid_o; the first tick after release starts a fresh frame at voice 0.

Configuration
REQ-031 Macro VOICE_SCHED_MUTE_EN defined: add input mute_i[2:0]. A muted voice is still sequenced (phase advances), but 0 is captured instead of wave_i.
REQ-032 Macro undefined: no mute_i port; wave_i is always captured.

Structure
REQ-033 Package tt6581_pkg shall hold NUM_VOICES_C, the sched_state_e enum (2-bit), the voice_cfg_t struct (freq, pw, wave_sel, sync, ring_mod), and WDT_CYCLES_C.
REQ-034 The block shall contain no sub-modules; the watchdog is an inline 4-bit counter, and the voice generator is a sibling instance at top level.

Verification
REQ-035 Reset, then a tick, with a generator model giving ready 3 cycles after start -> start_o pulses in cycles 1, 5 and 9 with act_voice_o 0, 1, 2; sample_valid_o in cycle 13.
REQ-036 Model returns wave_i 100, -200 and 511 for voices 0, 1, 2 -> voice_wave_o = {511, -200, 100} at sample_valid_o.
REQ-037 Second tick 6 cycles after the first -> overrun_o=1, exactly one sample_valid_o; status_clr_i then clears it.
REQ-038 Model never asserts ready for voice 1 -> timeout_o=1 after 8 cycles, voice 1 sample unchanged, voice 2 still serviced, sample_valid_o still pulses.
REQ-039 rst_ni low during voice 1 WAIT -> all outputs 0, no sample_valid_o; the next tick restarts at voice 0.
REQ-040 With VOICE_SCHED_MUTE_EN and mute_i=3'b010 -> voice_wave_o[1]=0, three start_o pulses still issued.

Source files
------------

// File: rtl/tt6581_pkg.sv
// tt6581_pkg: shared constants and types for the voice scheduler
package tt6581_pkg;
  localparam int NUM_VOICES_C = 3;
  localparam int WDT_CYCLES_C = 8;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} sched_state_e;
  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [3:0]  wave_sel;
    logic        sync;
    logic        ring_mod;
  } voice_cfg_t;
endpackage

// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if: command/response bus between the scheduler (master) and the voice generator (slave)
interface voice_scheduler_if;
  logic              start;
  logic [1:0]        act_voice;
  logic [15:0]       freq_word;
  logic [11:0]       pw_word;
  logic [3:0]        wave_sel;
  logic              sync;
  logic              ring_mod;
  logic              ready;
  logic signed [9:0] wave;
  modport master (output start, act_voice, freq_word, pw_word, wave_sel, sync, ring_mod, input ready, wave);
  modport slave (input start, act_voice, freq_word, pw_word, wave_sel, sync, ring_mod, output ready, wave);
endinterface

// File: rtl/voice_scheduler.sv
// voice_scheduler: runs each voice through the shared generator once per sample tick; VOICE_SCHED_MUTE_EN adds mute_i
module voice_scheduler
  import tt6581_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_C,
  parameter int WDT_CYCLES = WDT_CYCLES_C
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sample_tick_i,
  input  logic [NUM_VOICES-1:0][15:0]  freq_word_i,
  input  logic [NUM_VOICES-1:0][11:0]  pw_word_i,
  input  logic [NUM_VOICES-1:0][3:0]   wave_sel_i,
  input  logic [NUM_VOICES-1:0]        sync_i,
  input  logic [NUM_VOICES-1:0]        ring_mod_i,
`ifdef VOICE_SCHED_MUTE_EN
  input  logic [NUM_VOICES-1:0]        mute_i,
`endif
  input  logic                         status_clr_i,
  voice_scheduler_if.master            gen,
  output logic [NUM_VOICES-1:0][9:0]   voice_wave_o,
  output logic                         sample_valid_o,
  output logic                         busy_o,
  output logic                         overrun_o,
  output logic                         timeout_o
);
  sched_state_e r_state, w_next;
  logic [1:0]   r_act;
  logic [3:0]   r_wdt;
  voice_cfg_t   w_cfg;
  logic         w_wdt_exp, w_step, w_last, w_tick_drop;
  logic [9:0]   w_cap;

  assign w_wdt_exp   = r_wdt == 4'(WDT_CYCLES - 1);
  // a watchdog expiry advances the sequence exactly like a ready, minus the capture
  assign w_step      = r_state == S_WAIT && (gen.ready || w_wdt_exp);
  assign w_last      = r_act == 2'(NUM_VOICES - 1);
  assign w_tick_drop = sample_tick_i && r_state != S_IDLE;
`ifdef VOICE_SCHED_MUTE_EN
  assign w_cap = mute_i[r_act] ? '0 : gen.wave;
`else
  assign w_cap = gen.wave;
`endif

  assign w_cfg = '{freq: freq_word_i[r_act], pw: pw_word_i[r_act], wave_sel: wave_sel_i[r_act],
                   sync: sync_i[r_act], ring_mod: ring_mod_i[r_act]};
  assign gen.act_voice = r_act;
  assign gen.freq_word = w_cfg.freq;
  assign gen.pw_word   = w_cfg.pw;
  assign gen.wave_sel  = w_cfg.wave_sel;
  assign gen.sync      = w_cfg.sync;
  assign gen.ring_mod  = w_cfg.ring_mod;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = sample_tick_i ? S_START : S_IDLE;
      S_START: w_next = S_WAIT;
      S_WAIT:  w_next = !w_step ? S_WAIT : w_last ? S_DONE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    gen.start      = r_state == S_START;
    sample_valid_o = r_state == S_DONE;
    busy_o         = r_state != S_IDLE;
  end

  // status flags: a set event in the same cycle as status_clr_i wins
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_act        <= '0;
      r_wdt        <= '0;
      voice_wave_o <= '0;
      overrun_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && sample_tick_i) r_act <= '0;
      else if (w_step && !w_last) r_act <= r_act + 2'd1;
      r_wdt <= r_state == S_START ? '0 : r_state == S_WAIT ? r_wdt + 4'd1 : r_wdt;
      if (r_state == S_WAIT && gen.ready) voice_wave_o[r_act] <= w_cap;
      overrun_o <= w_tick_drop || (overrun_o && !status_clr_i);
      timeout_o <= (w_step && !gen.ready) || (timeout_o && !status_clr_i);
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: vector table, corner sequences and randomized frames checked against a frame-level model
module tb_voice_scheduler;
  localparam int WDT = 8;
  typedef struct {
    int lat[3];
    int wv[3];
    int es[3];
    int ev;
    int ew[3];
    bit eto;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, sample_tick = 1'b0, status_clr = 1'b0;
  logic [2:0][15:0] freq_w = '0;
  logic [2:0][11:0] pw_w = '0;
  logic [2:0][3:0]  ws_w = '0;
  logic [2:0]       sync_w = '0, ring_w = '0, mute_v = '0;
  logic [2:0][9:0]  voice_wave, val_wave;
  logic             sample_valid, busy, overrun, timeout;

  int n_tests = 0, n_fail = 0;
  int cyc, p_st, n_busy, e_val, nv;
  int e_st[3], m_wave[3], lat[4], wv[4];
  bit pend, spur, e_to, e_ov;
  logic [1:0] p_v;
  int st_cyc[$], st_act[$], val_cyc[$];
  logic [33:0] st_cfg[$];
  vec_t vt[6];

  voice_scheduler_if bus();

  voice_scheduler #(.NUM_VOICES(3), .WDT_CYCLES(WDT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(sample_tick),
    .freq_word_i(freq_w), .pw_word_i(pw_w), .wave_sel_i(ws_w), .sync_i(sync_w), .ring_mod_i(ring_w),
`ifdef VOICE_SCHED_MUTE_EN
    .mute_i(mute_v),
`endif
    .status_clr_i(status_clr), .gen(bus), .voice_wave_o(voice_wave),
    .sample_valid_o(sample_valid), .busy_o(busy), .overrun_o(overrun), .timeout_o(timeout)
  );

  always #10 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic signed [63:0] a, input logic signed [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, a, e);
    end
  endtask

  task automatic clear_log();
    st_cyc.delete(); st_act.delete(); st_cfg.delete(); val_cyc.delete();
    n_busy = 0; pend = 0; cyc = 0;
  endtask

  // one clock: record what the DUT shows, answer as the generator would, then advance
  task automatic step();
    bit rdy;
    if (bus.start) begin
      pend = 1; p_st = cyc; p_v = bus.act_voice;
      st_cyc.push_back(cyc); st_act.push_back(int'(bus.act_voice));
      st_cfg.push_back({bus.freq_word, bus.pw_word, bus.wave_sel, bus.sync, bus.ring_mod});
    end
    if (sample_valid) begin val_cyc.push_back(cyc); val_wave = voice_wave; end
    if (busy) n_busy++;
    rdy = pend && lat[p_v] != 0 && cyc == p_st + lat[p_v];
    bus.ready = rdy || (spur && (bus.start || sample_valid));
    bus.wave = rdy ? 10'(wv[p_v]) : 10'($urandom);
    if (rdy) pend = 0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_frame(input int tick2, input int clr_at);
    clear_log();
    sample_tick = 1; step(); sample_tick = 0;
    while (val_cyc.size() == 0 && cyc < 100) begin
      sample_tick = (cyc == tick2);
      status_clr = (cyc == clr_at);
      step();
    end
    sample_tick = 0; status_clr = 0;
    step();
    bus.ready = 0;
  endtask

  // frame timing from the rules: each voice takes its latency (capped by the watchdog) plus one START cycle
  task automatic predict();
    int s = 1;
    e_to = 0;
    for (int v = 0; v < 3; v++) begin
      int d;
      d = (lat[v] >= 1 && lat[v] <= WDT) ? lat[v] : WDT;
      e_st[v] = s;
      if (d != lat[v]) e_to = 1;
      else m_wave[v] = mute_v[v] ? 0 : wv[v];
      s += d + 1;
    end
    e_val = s;
  endtask

  task automatic check_frame(input string nm);
    chk({nm, " start_count"}, st_cyc.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < st_cyc.size()) begin
        chk($sformatf("%s start%0d_cycle", nm, k), st_cyc[k], e_st[k]);
        chk($sformatf("%s start%0d_voice", nm, k), st_act[k], k);
        chk($sformatf("%s start%0d_cfg", nm, k), st_cfg[k], {freq_w[k], pw_w[k], ws_w[k], sync_w[k], ring_w[k]});
      end
    chk({nm, " valid_count"}, val_cyc.size(), 1);
    chk({nm, " valid_cycle"}, val_cyc.size() > 0 ? val_cyc[0] : -1, e_val);
    chk({nm, " busy_cycles"}, n_busy, e_val);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s wave%0d", nm, k), $signed(val_wave[k]), m_wave[k]);
    chk({nm, " timeout"}, timeout, e_to);
    chk({nm, " overrun"}, overrun, e_ov);
    chk({nm, " busy_after"}, busy, 0);
  endtask

  task automatic clr_status();
    status_clr = 1; @(posedge clk); #1; status_clr = 0;
  endtask

  task automatic rand_cfg();
    for (int v = 0; v < 3; v++) begin
      freq_w[v] = 16'($urandom); pw_w[v] = 12'($urandom); ws_w[v] = 4'($urandom);
      sync_w[v] = 1'($urandom); ring_w[v] = 1'($urandom);
    end
  endtask

  task automatic set_gen(input int l0, input int l1, input int l2, input int w0, input int w1, input int w2);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = 0;
    wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " start"}, bus.start, 0);
    chk({nm, " act_voice"}, bus.act_voice, 0);
    chk({nm, " valid"}, sample_valid, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " overrun"}, overrun, 0);
    chk({nm, " timeout"}, timeout, 0);
    chk({nm, " waves"}, voice_wave, 0);
  endtask

  initial begin
    vt[0] = '{'{3, 3, 3}, '{100, -200, 511}, '{1, 5, 9},   13, '{100, -200, 511}, 1'b0};
    vt[1] = '{'{1, 1, 1}, '{1, 2, 3},        '{1, 3, 5},   7,  '{1, 2, 3},        1'b0};
    vt[2] = '{'{8, 8, 8}, '{-512, 77, 7},    '{1, 10, 19}, 28, '{-512, 77, 7},    1'b0};
    vt[3] = '{'{3, 0, 3}, '{5, 6, -7},       '{1, 5, 14},  18, '{5, 77, -7},      1'b1};
    vt[4] = '{'{2, 9, 4}, '{-1, 300, 8},     '{1, 4, 13},  18, '{-1, 77, 8},      1'b1};
    vt[5] = '{'{0, 0, 0}, '{9, 9, 9},        '{1, 10, 19}, 28, '{-1, 77, 8},      1'b1};
    bus.ready = 0; bus.wave = '0; spur = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle busy", busy, 0);

    for (int r = 0; r < 6; r++) begin
      clr_status(); rand_cfg();
      set_gen(vt[r].lat[0], vt[r].lat[1], vt[r].lat[2], vt[r].wv[0], vt[r].wv[1], vt[r].wv[2]);
      for (int v = 0; v < 3; v++) begin e_st[v] = vt[r].es[v]; m_wave[v] = vt[r].ew[v]; end
      e_val = vt[r].ev; e_to = vt[r].eto; e_ov = 0;
      run_frame(-1, -1);
      check_frame($sformatf("vec%0d", r));
    end

    bus.ready = 1; bus.wave = 10'sd123;
    repeat (2) begin @(posedge clk); #1; end
    bus.ready = 0;
    for (int v = 0; v < 3; v++) chk($sformatf("idle_ready wave%0d", v), $signed(voice_wave[v]), m_wave[v]);

    clr_status(); rand_cfg();
    set_gen(3, 3, 3, 11, -22, 33);
    predict(); e_ov = 1;
    run_frame(6, -1);
    check_frame("overrun");
    clr_status();
    chk("overrun cleared", overrun, 0);
    predict(); e_ov = 1;
    run_frame(4, 4);
    check_frame("set_wins");

    rand_cfg();
    set_gen(3, 3, 3, 40, 50, 60);
    clear_log();
    sample_tick = 1; step(); sample_tick = 0;
    while (cyc < 6) step();
    chk("midrst busy_before", busy, 1);
    chk("midrst voice_before", bus.act_voice, 1);
    rst_n = 0; pend = 0; bus.ready = 0;
    #2;
    chk_all_zero("midrst");
    nv = 0;
    repeat (3) begin @(posedge clk); #1; if (sample_valid) nv++; end
    chk("midrst no_valid", nv + val_cyc.size(), 0);
    rst_n = 1;
    for (int v = 0; v < 3; v++) m_wave[v] = 0;
    set_gen(3, 3, 3, -100, 200, -300);
    predict(); e_ov = 0;
    run_frame(-1, -1);
    check_frame("after_rst");

`ifdef VOICE_SCHED_MUTE_EN
    mute_v = 3'b010; rand_cfg();
    set_gen(3, 3, 3, 10, 20, 30);
    predict(); e_ov = 0;
    run_frame(-1, -1);
    check_frame("mute");
    mute_v = '0;
`endif

    for (int f = 0; f < 25; f++) begin
      int t2;
      clr_status(); rand_cfg();
      for (int v = 0; v < 3; v++) begin
        lat[v] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
        wv[v] = int'($urandom_range(0, 1023)) - 512;
      end
      lat[3] = 0;
      spur = 1'($urandom);
      t2 = $urandom_range(0, 1) ? int'($urandom_range(1, 40)) : -1;
      predict();
      e_ov = t2 >= 1 && t2 <= e_val;
      run_frame(t2, -1);
      check_frame($sformatf("rand%0d", f));
    end
    spur = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
